// File: rtl/btp_pkg.sv
// Shared definitions for the branch target predictor.
// Build option: define BTP_BHT_EN for 2-bit saturating direction counters;
// leave it undefined for 1-bit last-outcome direction state.
package btp_pkg;

  // Two-bit direction counter encodings, ordered so taken counts up
  typedef enum logic [1:0] {
    BTP_SNT = 2'b00,
    BTP_WNT = 2'b01,
    BTP_WT  = 2'b10,
    BTP_ST  = 2'b11
  } btp_bht_state_e;

  localparam int BTP_ENTRY_BITS_DEF = 6;
  localparam int BTP_CNT_W_DEF      = 32;

`ifdef BTP_BHT_EN
  localparam int                     BTP_STATE_W     = 2;
  localparam logic [BTP_STATE_W-1:0] BTP_STATE_RST   = BTP_WNT;
  localparam logic [BTP_STATE_W-1:0] BTP_STATE_ALLOC = BTP_WT;
`else
  localparam int                     BTP_STATE_W     = 1;
  localparam logic [BTP_STATE_W-1:0] BTP_STATE_RST   = 1'b0;
  localparam logic [BTP_STATE_W-1:0] BTP_STATE_ALLOC = 1'b1;
`endif

endpackage

// File: rtl/btp_sat_counter.sv
// Next-state function of the direction counter of one predictor entry.
// Width follows BTP_BHT_EN through btp_pkg (2 when defined, 1 otherwise);
// a 1-bit counter degenerates to "taken sets, not-taken clears".
module btp_sat_counter
  import btp_pkg::*;
#(
  parameter int W = BTP_STATE_W
) (
  input  logic [W-1:0] i_state,
  input  logic         i_taken,
  output logic [W-1:0] o_next
);

  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] MIN = '0;
  localparam logic [W-1:0] ONE = W'(1);

  function automatic logic [W-1:0] sat_step(input logic [W-1:0] s, input logic t);
    logic [W-1:0] n;
    n = s;
    if (t) begin
      if (s != MAX) n = s + ONE;
    end else begin
      if (s != MIN) n = s - ONE;
    end
    return n;
  endfunction

  // Saturating step toward taken or not-taken
  always_comb begin
    o_next = sat_step(i_state, i_taken);
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target predictor with combinational fetch lookup,
// EX-stage misprediction detection and resolution-time table update.
// Build option: BTP_BHT_EN selects 2-bit direction counters (else 1-bit).
module branch_target_predictor
  import btp_pkg::*;
#(
  parameter int ENTRY_BITS = BTP_ENTRY_BITS_DEF,
  parameter int CNT_W      = BTP_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      PCF,
  output logic             PredF,
  output logic [31:0]      NPC_PredF,
  input  logic             BranchE,
  input  logic             BrTakenE,
  input  logic [31:0]      PCE,
  input  logic [31:0]      BrTargetE,
  input  logic             PredE,
  input  logic [31:0]      NPC_PredE,
  output logic             MispredE,
  output logic [31:0]      RedirectPCE,
  output logic [CNT_W-1:0] BranchCnt,
  output logic [CNT_W-1:0] MispredCnt
);

  localparam int ENTRIES = 1 << ENTRY_BITS;
  localparam int TAG_W   = 32 - ENTRY_BITS - 2;

  // Table storage
  logic                   r_valid  [ENTRIES];
  logic [TAG_W-1:0]       r_tag    [ENTRIES];
  logic [31:0]            r_target [ENTRIES];
  logic [BTP_STATE_W-1:0] r_state  [ENTRIES];

  logic [ENTRY_BITS-1:0]  w_idx_f;
  logic [ENTRY_BITS-1:0]  w_idx_e;
  logic [TAG_W-1:0]       w_tag_f;
  logic [TAG_W-1:0]       w_tag_e;
  logic                   w_hit_f;
  logic                   w_hit_e;
  logic [31:0]            w_pcf_plus4;
  logic [31:0]            w_pce_plus4;
  logic [BTP_STATE_W-1:0] w_state_next;
  logic                   w_unused;

  // Byte-offset bits never participate in indexing or tagging
  assign w_unused = ^{PCF[1:0], PCE[1:0]};

  assign w_idx_f = PCF[ENTRY_BITS+1:2];
  assign w_tag_f = PCF[31:ENTRY_BITS+2];
  assign w_idx_e = PCE[ENTRY_BITS+1:2];
  assign w_tag_e = PCE[31:ENTRY_BITS+2];

  // 32-bit adds wrap naturally, so 0xFFFFFFFC + 4 = 0
  assign w_pcf_plus4 = PCF + 32'd4;
  assign w_pce_plus4 = PCE + 32'd4;

  assign w_hit_f = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
  assign w_hit_e = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);

  btp_sat_counter #(
    .W(BTP_STATE_W)
  ) u_sat_counter (
    .i_state (r_state[w_idx_e]),
    .i_taken (BrTakenE),
    .o_next  (w_state_next)
  );

  // Fetch lookup reads registered state, so a same-cycle update is seen next cycle
  always_comb begin
    PredF     = 1'b0;
    NPC_PredF = w_pcf_plus4;
    if (!rst && w_hit_f && r_state[w_idx_f][BTP_STATE_W-1]) begin
      PredF     = 1'b1;
      NPC_PredF = r_target[w_idx_f];
    end
  end

  // EX-stage check of the carried prediction against the resolved branch
  always_comb begin
    MispredE    = 1'b0;
    RedirectPCE = BrTakenE ? BrTargetE : w_pce_plus4;
    if (BranchE) begin
      MispredE = (PredE != BrTakenE) || (BrTakenE && (NPC_PredE != BrTargetE));
    end
  end

  // Table update on resolution: allocate on taken miss, train on hit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_state[i]  <= BTP_STATE_RST;
      end
    end else if (BranchE) begin
      if (w_hit_e) begin
        if (BrTakenE) r_target[w_idx_e] <= BrTargetE;
        r_state[w_idx_e] <= w_state_next;
      end else if (BrTakenE) begin
        // A conflicting entry is simply overwritten
        r_valid[w_idx_e]  <= 1'b1;
        r_tag[w_idx_e]    <= w_tag_e;
        r_target[w_idx_e] <= BrTargetE;
        r_state[w_idx_e]  <= BTP_STATE_ALLOC;
      end
    end
  end

  // Branch and misprediction statistics, wrapping at 2^CNT_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      BranchCnt  <= '0;
      MispredCnt <= '0;
    end else begin
      if (BranchE)  BranchCnt  <= BranchCnt + 1'b1;
      if (MispredE) MispredCnt <= MispredCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed self-checking bench for branch_target_predictor (default widths).
// Expectations hold for both BTP_BHT_EN settings.
module tb_branch_target_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] PCF;
  logic        PredF;
  logic [31:0] NPC_PredF;
  logic        BranchE;
  logic        BrTakenE;
  logic [31:0] PCE;
  logic [31:0] BrTargetE;
  logic        PredE;
  logic [31:0] NPC_PredE;
  logic        MispredE;
  logic [31:0] RedirectPCE;
  logic [31:0] BranchCnt;
  logic [31:0] MispredCnt;

  int n_chk  = 0;
  int n_fail = 0;

  branch_target_predictor dut (
    .clk         (clk),
    .rst         (rst),
    .PCF         (PCF),
    .PredF       (PredF),
    .NPC_PredF   (NPC_PredF),
    .BranchE     (BranchE),
    .BrTakenE    (BrTakenE),
    .PCE         (PCE),
    .BrTargetE   (BrTargetE),
    .PredE       (PredE),
    .NPC_PredE   (NPC_PredE),
    .MispredE    (MispredE),
    .RedirectPCE (RedirectPCE),
    .BranchCnt   (BranchCnt),
    .MispredCnt  (MispredCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic br(input logic taken, input logic [31:0] pce, input logic [31:0] tgt,
                    input logic prede, input logic [31:0] npce);
    BranchE   = 1'b1;
    BrTakenE  = taken;
    PCE       = pce;
    BrTargetE = tgt;
    PredE     = prede;
    NPC_PredE = npce;
  endtask

  task automatic idle();
    BranchE   = 1'b0;
    BrTakenE  = 1'b0;
    PredE     = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    PCF = 32'h100;
    idle();
    PCE = 32'h0;
    BrTargetE = 32'h0;
    NPC_PredE = 32'h0;
    // Update presented while in reset must be dropped
    br(1'b1, 32'h300, 32'h400, 1'b0, 32'h304);
    #1;
    chk("rst_predf", {31'b0, PredF}, 32'h0);
    chk("rst_npc", NPC_PredF, 32'h104);
    step();
    chk("rst_brcnt", BranchCnt, 32'h0);
    chk("rst_mpcnt", MispredCnt, 32'h0);
    idle();
    rst = 1'b0;
    PCF = 32'h300;
    #1;
    chk("rst_upd_dropped", {31'b0, PredF}, 32'h0);

    // Cold lookup
    PCF = 32'h100;
    #1;
    chk("cold_predf", {31'b0, PredF}, 32'h0);
    chk("cold_npc", NPC_PredF, 32'h104);
    // Mispredict suppressed when no branch in EX
    PredE = 1'b1;
    #1;
    chk("nobranch_mispred", {31'b0, MispredE}, 32'h0);

    // First taken resolution allocates; same-cycle lookup sees old entry
    step();
    br(1'b1, 32'h100, 32'h200, 1'b0, 32'h104);
    #1;
    chk("alloc_mispred", {31'b0, MispredE}, 32'h1);
    chk("alloc_redirect", RedirectPCE, 32'h200);
    chk("war_predf_old", {31'b0, PredF}, 32'h0);
    chk("war_npc_old", NPC_PredF, 32'h104);
    step();
    idle();
    #1;
    chk("alloc_predf", {31'b0, PredF}, 32'h1);
    chk("alloc_npc", NPC_PredF, 32'h200);
    chk("alloc_brcnt", BranchCnt, 32'd1);
    chk("alloc_mpcnt", MispredCnt, 32'd1);

    // Three not-taken resolutions train the entry down
    br(1'b0, 32'h100, 32'h200, 1'b1, 32'h200);
    #1;
    chk("nt1_mispred", {31'b0, MispredE}, 32'h1);
    chk("nt1_redirect", RedirectPCE, 32'h104);
    step();
    chk("nt1_predf", {31'b0, PredF}, 32'h0);
    br(1'b0, 32'h100, 32'h200, 1'b0, 32'h104);
    #1;
    chk("nt2_mispred", {31'b0, MispredE}, 32'h0);
    step();
    br(1'b0, 32'h100, 32'h200, 1'b0, 32'h104);
    step();
    idle();
    #1;
    chk("nt3_predf", {31'b0, PredF}, 32'h0);
    chk("nt3_npc", NPC_PredF, 32'h104);
    chk("nt3_brcnt", BranchCnt, 32'd4);
    chk("nt3_mpcnt", MispredCnt, 32'd2);

    // Aliasing PC shares index 0 and replaces the entry
    br(1'b1, 32'h200, 32'h500, 1'b0, 32'h204);
    step();
    idle();
    PCF = 32'h100;
    #1;
    chk("alias_old_predf", {31'b0, PredF}, 32'h0);
    chk("alias_old_npc", NPC_PredF, 32'h104);
    PCF = 32'h200;
    #1;
    chk("alias_new_predf", {31'b0, PredF}, 32'h1);
    chk("alias_new_npc", NPC_PredF, 32'h500);

    // Correct direction but wrong target is a mispredict; target rewritten
    br(1'b1, 32'h200, 32'h540, 1'b1, 32'h500);
    #1;
    chk("tgt_mispred", {31'b0, MispredE}, 32'h1);
    chk("tgt_redirect", RedirectPCE, 32'h540);
    chk("tgt_war_npc", NPC_PredF, 32'h500);
    step();
    idle();
    #1;
    chk("tgt_new_npc", NPC_PredF, 32'h540);
    chk("tgt_brcnt", BranchCnt, 32'd6);
    chk("tgt_mpcnt", MispredCnt, 32'd4);

    // Top-of-address-space wrap for both +4 paths
    PCF = 32'hFFFF_FFFC;
    br(1'b0, 32'hFFFF_FFFC, 32'h0000_1000, 1'b1, 32'h0000_1000);
    #1;
    chk("wrap_npcf", NPC_PredF, 32'h0);
    chk("wrap_redirect", RedirectPCE, 32'h0);
    chk("wrap_mispred", {31'b0, MispredE}, 32'h1);
    step();
    idle();
    #1;
    chk("nt_miss_noalloc", {31'b0, PredF}, 32'h0);

    // Not-taken with correct direction ignores target mismatch
    br(1'b0, 32'h300, 32'h999, 1'b0, 32'h304);
    #1;
    chk("nt_tgt_ignored", {31'b0, MispredE}, 32'h0);
    step();
    idle();
    chk("pre_rst_brcnt", BranchCnt, 32'd8);

    // Asynchronous reset mid-run clears table and counters immediately
    PCF = 32'h200;
    #1;
    chk("pre_rst_predf", {31'b0, PredF}, 32'h1);
    rst = 1'b1;
    #1;
    chk("async_predf", {31'b0, PredF}, 32'h0);
    chk("async_npc", NPC_PredF, 32'h204);
    chk("async_brcnt", BranchCnt, 32'h0);
    chk("async_mpcnt", MispredCnt, 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_predf", {31'b0, PredF}, 32'h0);

    // Re-allocate, then a single not-taken removes the taken prediction
    step();
    br(1'b1, 32'h200, 32'h600, 1'b0, 32'h204);
    step();
    idle();
    #1;
    chk("realloc_npc", NPC_PredF, 32'h600);
    br(1'b0, 32'h200, 32'h600, 1'b1, 32'h600);
    step();
    idle();
    #1;
    chk("single_nt_predf", {31'b0, PredF}, 32'h0);
    chk("final_brcnt", BranchCnt, 32'd2);
    chk("final_mpcnt", MispredCnt, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_target_predictor.md
BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

Interface
REQ-001 SHALL have parameter ENTRY_BITS, default 6, log2 of table entries (64 entries).
REQ-002 SHALL have parameter CNT_W, default 32, width of statistics counters.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port PCF  input  32  fetch-stage PC being looked up.
REQ-006 SHALL have port PredF  output  1  predict taken for PCF.
REQ-007 SHALL have port NPC_PredF  output  32  predicted next PC: stored target if PredF, else PCF+4.
REQ-008 SHALL have port BranchE  input  1  EX stage holds a conditional branch (resolved this cycle).
REQ-009 SHALL have port BrTakenE  input  1  actual branch outcome.
REQ-010 SHALL have port PCE  input  32  PC of resolving branch.
REQ-011 SHALL have port BrTargetE  input  32  actual taken target.
REQ-012 SHALL have port PredE, NPC_PredE  input  1/32  prediction carried down the pipeline for PCE.
REQ-013 SHALL have port MispredE  output  1  EX prediction wrong; pipeline must flush and redirect.
REQ-014 SHALL have port RedirectPCE  output  32  correct next PC on mispredict (BrTargetE if taken, else PCE+4).
REQ-015 SHALL have ports BranchCnt, MispredCnt  output  CNT_W  statistics counters.

Function
REQ-016 SHALL index the table with PC[ENTRY_BITS+1:2]; tag = PC[31:ENTRY_BITS+2]; entry = valid, tag, target, state.
REQ-017 SHALL perform lookup combinationally (zero latency): hit = valid && tag match; PredF = hit && state predicts taken.
REQ-018 SHALL compute MispredE combinationally = BranchE && ((PredE != BrTakenE) || (BrTakenE && NPC_PredE != BrTargetE)); 0 when BranchE=0.
REQ-019 SHALL update on the clock edge when BranchE=1: on tag miss and BrTakenE=1 allocate entry (valid=1, tag, target, state=weakly-taken); on tag miss and not taken do nothing; on hit write target (if taken) and step state.
REQ-020 SHALL step state as 2-bit saturating counter SNT(00)<->WNT(01)<->WT(10)<->ST(11); taken increments, not-taken decrements; saturate at 00 and 11; predict taken when state[1]=1.
REQ-021 SHALL, when lookup and update hit the same index in one cycle, return the pre-update entry to PredF/NPC_PredF (write-after-read).
REQ-022 SHALL increment BranchCnt on each BranchE=1 cycle and MispredCnt on each MispredE=1 cycle; both wrap modulo 2^CNT_W.
REQ-023 SHALL replace conflicting entries unconditionally (direct-mapped, no associativity).
REQ-024 SHALL compute PCF+4 and PCE+4 modulo 2^32 (0xFFFFFFFC+4 = 0).

Reset
REQ-025 SHALL on rst=1, asynchronously and regardless of clock, clear all valid bits, set all states to WNT, clear BranchCnt and MispredCnt.
REQ-026 SHALL, while rst=1, drive PredF=0 and NPC_PredF=PCF+4; an update arriving while rst is asserted SHALL be discarded.

Configuration
REQ-027 SHALL honour macro BTP_BHT_EN: defined -> 2-bit counter behaviour of REQ-020; undefined -> 1-bit state (taken sets, not-taken clears), allocation sets state=1, PredF = hit && state.

Structure
REQ-028 SHALL place state encodings (SNT/WNT/WT/ST) and default widths in shared package btp_pkg.
REQ-029 SHALL implement counter stepping in sub-module btp_sat_counter (next-state function, width 2 or 1 per BTP_BHT_EN).

Verification
REQ-030 Bench: after reset, PCF=0x100 -> PredF=0, NPC_PredF=0x104.
REQ-031 Bench: resolve taken branch PCE=0x100, BrTargetE=0x200, PredE=0 -> MispredE=1, RedirectPCE=0x200; next cycle PCF=0x100 -> PredF=1, NPC_PredF=0x200.
REQ-032 Bench: three not-taken resolutions of 0x100 from WT -> state SNT, PredF=0; MispredCnt counts only cycles with wrong prediction.
REQ-033 Bench: aliasing PC 0x100+(4<<ENTRY_BITS) taken -> replaces entry; lookup of 0x100 misses (PredF=0).
REQ-034 Bench: same-cycle PCF=PCE=0x100 update -> PredF reflects old entry; new value visible next cycle.
REQ-035 Bench: assert rst mid-run with populated table -> PredF=0 immediately, counters 0; with BTP_BHT_EN undefined single not-taken clears prediction.
